syn_sram_rsp: RTL and testbench
===============================

SYN_SRAM_RSP -- requirements
Module: syn_sram_rsp

Interface
REQ-001 Parameter MEM_AW, default 10: modelled address bits; SRAM_ADDR[MEM_AW-1:0] indexes the array, upper bits ignored (aliasing).
REQ-002 Parameter RD_LAT, default 1: read latency in clk_ir cycles, legal range 1..4.
REQ-003 One clock; reset is asynchronous and active-low. clk_ir  input  1  block clock, all state on rising edge.
REQ-004 rst_il  input  1  asynchronous active-low reset.
REQ-005 SRAM_ADDR  input  18  word address from the SRAM initiator.
REQ-006 SRAM_LB_N / SRAM_UB_N  input  1 each  low-byte / high-byte lane enable, active low.
REQ-007 SRAM_CE_N / SRAM_OE_N / SRAM_WE_N  input  1 each  chip, output and write enables, active low.
REQ-008 SRAM_DQ  inout  16  data bus; driven only per REQ-016, otherwise high-Z.
REQ-009 wr_cnt_o  output  16  count of committed writes, saturating at 0xFFFF.
REQ-010 rd_cnt_o  output  16  count of accepted reads, saturating at 0xFFFF.
REQ-011 proto_err_o  output  1  sticky protocol-violation flag.

Function
REQ-012 Every edge registers ADDR, LB_N, UB_N, CE_N, OE_N, WE_N and SRAM_DQ into a capture stage; all decode uses the captured copy.
REQ-013 Decode: CE_N=1 -> IDLE; CE_N=0, WE_N=0 -> WRITE (WE has priority over OE); CE_N=0, WE_N=1, OE_N=0 -> READ; CE_N=0, WE_N=1, OE_N=1 -> IDLE.
REQ-014 A WRITE captured at edge k commits at edge k+1: mem[addr][7:0] updated iff LB_N=0, mem[addr][15:8] updated iff UB_N=0; wr_cnt_o increments iff at least one lane is enabled.
REQ-015 A READ captured at edge k enters a RD_LAT-deep pipeline carrying {valid, lb_en, ub_en, data}; data is mem[addr] with forwarding of any write committing at the same edge (per enabled lane), so write-then-read to one address returns the new data.
REQ-016 Pipeline output drives SRAM_DQ[7:0] iff valid and lb_en, SRAM_DQ[15:8] iff valid and ub_en, from edge k+RD_LAT for exactly one cycle; each captured cycle is independent, so back-to-back READs stream one word per cycle.
REQ-017 rd_cnt_o increments once per captured READ cycle, regardless of lane enables.
REQ-018 Any pipeline stage still valid when a WRITE is captured is discarded (bus turnaround); the block never drives SRAM_DQ in a cycle whose captured decode is WRITE.
REQ-019 proto_err_o sets and stays set when: CE_N=0 with WE_N=0 and OE_N=0 in the same captured cycle (write still performed), or a READ is captured with LB_N=1 and UB_N=1.
REQ-020 Counters saturate; no wrap-around to zero.
REQ-021 Address aliasing: ADDR values differing only above MEM_AW-1 access the same word, with no error.

Reset
REQ-022 While rst_il=0: capture stage IDLE, read pipeline invalid, SRAM_DQ high-Z, wr_cnt_o=0, rd_cnt_o=0, proto_err_o=0.
REQ-023 Memory array contents are not reset; reads of never-written words return X in simulation.
REQ-024 Reset asserted mid-read drops all pending read data immediately (asynchronous); a write captured before reset but not yet committed is discarded.
REQ-025 After rst_il deasserts, the first capture occurs at the next rising edge.

Verification
REQ-026 Write 0x1234 to addr 0x005 (LB_N=UB_N=0), then read addr 0x005 with RD_LAT=1 -> SRAM_DQ=0x1234 one cycle after read capture; wr_cnt_o=1, rd_cnt_o=1.
REQ-027 Write 0xFFFF to addr 0x010, then write 0xAB00 with UB_N=0, LB_N=1 -> read returns 0xABFF; a read with LB_N=1 drives SRAM_DQ=0xABzz.
REQ-028 Write 0x5A5A to addr 0x020 and read it in the next cycle (RD_LAT=3) -> 0x5A5A appears three cycles after read capture; four back-to-back reads of addrs 0..3 return four consecutive words.
REQ-029 CE_N=0, WE_N=0, OE_N=0 with DQ=0x0F0F at addr 0x030 -> proto_err_o=1 and stays 1; SRAM_DQ not driven; later read of 0x030 returns 0x0F0F.
REQ-030 Issue 0x10000 writes -> wr_cnt_o holds 0xFFFF; assert rst_il=0 during a pending read -> SRAM_DQ high-Z at once, counters 0.
REQ-031 With MEM_AW=10, write 0xBEEF to addr 0x00400 -> read of addr 0x00000 returns 0xBEEF.

Source files
------------

// File: rtl/syn_sram_rsp.sv
// Behavioural responder for an asynchronous-style 16-bit SRAM bus.
// Registers the bus every edge, commits writes one edge later, returns reads after RD_LAT edges.
module syn_sram_rsp #(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic        clk_ir,
  input  logic        rst_il,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_WE_N,
  inout  wire  [15:0] SRAM_DQ,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] rd_cnt_o,
  output logic        proto_err_o
);

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  logic [MEM_AW-1:0] cap_addr;
  logic              cap_lb_n;
  logic              cap_ub_n;
  logic              cap_ce_n;
  logic              cap_oe_n;
  logic              cap_we_n;
  logic [15:0]       cap_dq;
  cmd_e              cmd;

  logic [15:0]       mem [2**MEM_AW];
  logic [15:0]       rd_word;

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_lb;
  logic [RD_LAT-1:0] pipe_ub;
  logic [15:0]       pipe_data [RD_LAT];
  logic              drv_lb;
  logic              drv_ub;

  // Address bits above MEM_AW alias onto the same word and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^SRAM_ADDR[17:MEM_AW];

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      cap_addr <= '0;
      cap_lb_n <= 1'b1;
      cap_ub_n <= 1'b1;
      cap_ce_n <= 1'b1;
      cap_oe_n <= 1'b1;
      cap_we_n <= 1'b1;
      cap_dq   <= '0;
    end else begin
      cap_addr <= SRAM_ADDR[MEM_AW-1:0];
      cap_lb_n <= SRAM_LB_N;
      cap_ub_n <= SRAM_UB_N;
      cap_ce_n <= SRAM_CE_N;
      cap_oe_n <= SRAM_OE_N;
      cap_we_n <= SRAM_WE_N;
      cap_dq   <= SRAM_DQ;
    end
  end

  // Bus protocol: CE_N gates everything, WE_N low wins over OE_N low, all strobes active low.
  always_comb begin
    cmd = CMD_IDLE;
    if (!cap_ce_n) begin
      if (!cap_we_n)      cmd = CMD_WRITE;
      else if (!cap_oe_n) cmd = CMD_READ;
    end
  end

  always_ff @(posedge clk_ir) begin
    if (cmd == CMD_WRITE) begin
      if (!cap_lb_n) mem[cap_addr][7:0]  <= cap_dq[7:0];
      if (!cap_ub_n) mem[cap_addr][15:8] <= cap_dq[15:8];
    end
  end

  // A write captured one edge before a read has already landed in the array when the
  // read samples it, so the array output already carries the forwarded data.
  assign rd_word = mem[cap_addr];

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pipe_vld <= '0;
      pipe_lb  <= '0;
      pipe_ub  <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else if (cmd == CMD_WRITE) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0]  <= (cmd == CMD_READ);
      pipe_lb[0]   <= !cap_lb_n;
      pipe_ub[0]   <= !cap_ub_n;
      pipe_data[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_lb[i]   <= pipe_lb[i-1];
        pipe_ub[i]   <= pipe_ub[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign drv_lb = pipe_vld[RD_LAT-1] && pipe_lb[RD_LAT-1] && (cmd != CMD_WRITE);
  assign drv_ub = pipe_vld[RD_LAT-1] && pipe_ub[RD_LAT-1] && (cmd != CMD_WRITE);

  assign SRAM_DQ[7:0]  = drv_lb ? pipe_data[RD_LAT-1][7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = drv_ub ? pipe_data[RD_LAT-1][15:8] : 8'hzz;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_cnt_o    <= '0;
      rd_cnt_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if ((cmd == CMD_WRITE) && (!cap_lb_n || !cap_ub_n) && (wr_cnt_o != 16'hFFFF))
        wr_cnt_o <= wr_cnt_o + 16'd1;
      if ((cmd == CMD_READ) && (rd_cnt_o != 16'hFFFF))
        rd_cnt_o <= rd_cnt_o + 16'd1;
      if ((!cap_ce_n && !cap_we_n && !cap_oe_n) ||
          ((cmd == CMD_READ) && cap_lb_n && cap_ub_n))
        proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_sram_rsp.sv
// Directed bench for syn_sram_rsp: one RD_LAT=1 and one RD_LAT=3 instance share the same bus stimulus.
// Both data buses are pulled up, so an undriven byte lane reads as 8'hFF.
module tb_syn_sram_rsp;

  logic        clk_ir;
  logic        rst_il;
  logic [17:0] addr;
  logic        lb_n, ub_n, ce_n, oe_n, we_n;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  wire  [15:0] dq1;
  wire  [15:0] dq3;
  logic [15:0] wr_cnt1, rd_cnt1, wr_cnt3, rd_cnt3;
  logic        proto1, proto3;

  int total = 0;
  int bad   = 0;

  pullup pu1 (dq1);
  pullup pu3 (dq3);
  assign dq1 = tb_dq_en ? tb_dq : 16'hzzzz;
  assign dq3 = tb_dq_en ? tb_dq : 16'hzzzz;

  syn_sram_rsp #(.MEM_AW(10), .RD_LAT(1)) u_dut1 (
    .clk_ir(clk_ir), .rst_il(rst_il), .SRAM_ADDR(addr),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_DQ(dq1),
    .wr_cnt_o(wr_cnt1), .rd_cnt_o(rd_cnt1), .proto_err_o(proto1)
  );

  syn_sram_rsp #(.MEM_AW(10), .RD_LAT(3)) u_dut3 (
    .clk_ir(clk_ir), .rst_il(rst_il), .SRAM_ADDR(addr),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_DQ(dq3),
    .wr_cnt_o(wr_cnt3), .rd_cnt_o(rd_cnt3), .proto_err_o(proto3)
  );

  // Clock and reset
  initial clk_ir = 1'b0;
  always #5 clk_ir = ~clk_ir;

  // Driver tasks
  task automatic cyc();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    lb_n = 1'b0; ub_n = 1'b0;
    tb_dq_en = 1'b0;
  endtask

  task automatic idle_n(input int n);
    idle();
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic l, input logic u);
    addr = a; tb_dq = d; tb_dq_en = 1'b1;
    lb_n = l; ub_n = u;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [17:0] a, input logic l, input logic u);
    tb_dq_en = 1'b0;
    addr = a; lb_n = l; ub_n = u;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    cyc();
  endtask

  task automatic conflict(input logic [17:0] a, input logic [15:0] d);
    addr = a; tb_dq = d; tb_dq_en = 1'b1;
    lb_n = 1'b0; ub_n = 1'b0;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    cyc();
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_il = 1'b0;
    addr = '0;
    tb_dq = '0;
    idle();
    repeat (2) cyc();
    chk("rst_wr_cnt", wr_cnt1, 16'h0000);
    chk("rst_rd_cnt", rd_cnt1, 16'h0000);
    chk("rst_proto", {15'd0, proto1}, 16'h0000);
    chk("rst_dq", dq1, 16'hFFFF);
    rst_il = 1'b1;

    // Write then read, both latencies
    wr(18'h005, 16'h1234, 1'b0, 1'b0);
    rd(18'h005, 1'b0, 1'b0);
    idle(); cyc();
    chk("a_rd1", dq1, 16'h1234);
    chk("a_wr_cnt", wr_cnt1, 16'd1);
    chk("a_rd_cnt", rd_cnt1, 16'd1);
    cyc();
    chk("a_rd1_one_cycle", dq1, 16'hFFFF);
    cyc();
    chk("a_rd3", dq3, 16'h1234);
    idle_n(4);

    // Byte lanes
    wr(18'h010, 16'hFFFF, 1'b0, 1'b0);
    wr(18'h010, 16'hAB00, 1'b1, 1'b0);
    wr(18'h010, 16'h0000, 1'b1, 1'b1);
    rd(18'h010, 1'b0, 1'b0);
    idle(); cyc();
    chk("b_merge", dq1, 16'hABFF);
    rd(18'h010, 1'b1, 1'b0);
    idle(); cyc();
    chk("b_ub_only_10", dq1, 16'hABFF);
    rd(18'h005, 1'b1, 1'b0);
    idle(); cyc();
    chk("b_ub_only_05", dq1, 16'h12FF);
    rd(18'h005, 1'b0, 1'b1);
    idle(); cyc();
    chk("b_lb_only_05", dq1, 16'hFF34);
    chk("b_wr_cnt", wr_cnt1, 16'd3);
    chk("b_rd_cnt", rd_cnt1, 16'd5);
    chk("b_proto", {15'd0, proto1}, 16'h0000);
    idle_n(4);

    // RD_LAT=3 latency and streaming
    wr(18'h020, 16'h5A5A, 1'b0, 1'b0);
    rd(18'h020, 1'b0, 1'b0);
    idle(); cyc(); cyc();
    chk("c_lat3_early", dq3, 16'hFFFF);
    cyc();
    chk("c_lat3", dq3, 16'h5A5A);
    idle_n(4);
    wr(18'h000, 16'hA0A0, 1'b0, 1'b0);
    wr(18'h001, 16'hB1B1, 1'b0, 1'b0);
    wr(18'h002, 16'hC2C2, 1'b0, 1'b0);
    wr(18'h003, 16'hD3D3, 1'b0, 1'b0);
    rd(18'h000, 1'b0, 1'b0);
    rd(18'h001, 1'b0, 1'b0);
    rd(18'h002, 1'b0, 1'b0);
    rd(18'h003, 1'b0, 1'b0);
    chk("c_stream0", dq3, 16'hA0A0);
    idle(); cyc();
    chk("c_stream1", dq3, 16'hB1B1);
    cyc();
    chk("c_stream2", dq3, 16'hC2C2);
    cyc();
    chk("c_stream3", dq3, 16'hD3D3);
    cyc();
    chk("c_stream_end", dq3, 16'hFFFF);
    idle_n(4);

    // WE and OE both low, with a read in flight
    rd(18'h005, 1'b0, 1'b0);
    conflict(18'h030, 16'h0F0F);
    tb_dq_en = 1'b0;
    #1;
    chk("d_no_drive1", dq1, 16'hFFFF);
    chk("d_no_drive3", dq3, 16'hFFFF);
    idle(); cyc();
    chk("d_proto", {15'd0, proto1}, 16'h0001);
    cyc();
    chk("d_discard3", dq3, 16'hFFFF);
    rd(18'h030, 1'b0, 1'b0);
    idle(); cyc();
    chk("d_rd_030", dq1, 16'h0F0F);
    chk("d_proto_sticky", {15'd0, proto1}, 16'h0001);
    chk("d_wr_cnt", wr_cnt1, 16'd9);
    chk("d_rd_cnt", rd_cnt1, 16'd12);
    chk("d_rd_cnt3", rd_cnt3, 16'd12);
    idle_n(4);

    // Write counter saturation
    for (int i = 0; i < 65536; i++) wr(18'h100, i[15:0], 1'b0, 1'b0);
    idle(); cyc(); cyc();
    chk("e_wr_sat", wr_cnt1, 16'hFFFF);
    wr(18'h100, 16'h0001, 1'b0, 1'b0);
    idle(); cyc();
    chk("e_wr_sat_hold", wr_cnt1, 16'hFFFF);

    // Reset during a pending read
    rd(18'h030, 1'b0, 1'b0);
    idle(); cyc();
    chk("e_pre_rst_rd", dq1, 16'h0F0F);
    rst_il = 1'b0;
    #1;
    chk("e_rst_dq1", dq1, 16'hFFFF);
    chk("e_rst_wr_cnt", wr_cnt1, 16'h0000);
    chk("e_rst_rd_cnt", rd_cnt1, 16'h0000);
    chk("e_rst_proto", {15'd0, proto1}, 16'h0000);
    cyc(); cyc();
    chk("e_rst_dq3", dq3, 16'hFFFF);
    rst_il = 1'b1;
    idle_n(2);

    // Reset between write capture and commit
    wr(18'h050, 16'h2222, 1'b0, 1'b0);
    wr(18'h050, 16'h1111, 1'b0, 1'b0);
    idle();
    rst_il = 1'b0;
    #1;
    cyc();
    rst_il = 1'b1;
    chk("e_mid_wr_cnt", wr_cnt1, 16'h0000);
    rd(18'h050, 1'b0, 1'b0);
    idle(); cyc();
    chk("e_mid_wr_data", dq1, 16'h2222);
    chk("e_proto_clear", {15'd0, proto1}, 16'h0000);
    rd(18'h050, 1'b1, 1'b1);
    idle(); cyc();
    chk("e_nolane_dq", dq1, 16'hFFFF);
    chk("e_nolane_proto", {15'd0, proto1}, 16'h0001);
    chk("e_nolane_rd_cnt", rd_cnt1, 16'd2);
    idle_n(4);

    // Address aliasing
    wr(18'h00400, 16'hBEEF, 1'b0, 1'b0);
    rd(18'h00000, 1'b0, 1'b0);
    idle(); cyc();
    chk("f_alias_0", dq1, 16'hBEEF);
    rd(18'h3FC00, 1'b0, 1'b0);
    idle(); cyc();
    chk("f_alias_hi", dq1, 16'hBEEF);
    chk("f_wr_cnt", wr_cnt1, 16'd1);
    chk("f_rd_cnt", rd_cnt1, 16'd4);
    chk("f_wr_cnt3", wr_cnt3, 16'd1);
    idle_n(4);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
